// File: rtl/decode_exe_stage.sv
// decode_exe_stage: D->E pipeline register with stall, flush and valid; optional PIPE_PERF_CNT_EN adds stall/flush counters
module decode_exe_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int ALUCTL_W = 3,
  parameter int COND_W   = 4,
  parameter int FLAG_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stallE,
  input  logic                flushE,
  input  logic                validD,
  input  logic [DATA_W-1:0]   RD1D,
  input  logic [DATA_W-1:0]   RD2D,
  input  logic [DATA_W-1:0]   ExtImmD,
  input  logic [REG_AW-1:0]   RA1D,
  input  logic [REG_AW-1:0]   RA2D,
  input  logic [REG_AW-1:0]   WA3D,
  input  logic [COND_W-1:0]   CondD,
  input  logic [FLAG_W-1:0]   FlagsD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic                PCSrcD,
  input  logic                RegWriteD,
  input  logic                MemtoRegD,
  input  logic                MemWriteD,
  input  logic                ALUSrcD,
  input  logic                FlagWriteD,
  output logic                validE,
  output logic [DATA_W-1:0]   RD1E,
  output logic [DATA_W-1:0]   RD2E,
  output logic [DATA_W-1:0]   ExtImmE,
  output logic [REG_AW-1:0]   RA1E,
  output logic [REG_AW-1:0]   RA2E,
  output logic [REG_AW-1:0]   WA3E,
  output logic [COND_W-1:0]   CondE,
  output logic [FLAG_W-1:0]   FlagsE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                PCSrcE,
  output logic                RegWriteE,
  output logic                MemtoRegE,
  output logic                MemWriteE,
  output logic                ALUSrcE,
  output logic                FlagWriteE
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);
  always_ff @(posedge clk)
    if (reset || flushE) begin
      validE      <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ExtImmE     <= '0;
      RA1E        <= '0;
      RA2E        <= '0;
      WA3E        <= '0;
      CondE       <= '0;
      FlagsE      <= '0;
      ALUControlE <= '0;
      PCSrcE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      FlagWriteE  <= 1'b0;
    end else if (!stallE) begin
      validE      <= validD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ExtImmE     <= ExtImmD;
      RA1E        <= RA1D;
      RA2E        <= RA2D;
      WA3E        <= WA3D;
      CondE       <= CondD;
      FlagsE      <= FlagsD;
      ALUControlE <= ALUControlD;
      PCSrcE      <= PCSrcD & validD;
      RegWriteE   <= RegWriteD & validD;
      MemtoRegE   <= MemtoRegD & validD;
      MemWriteE   <= MemWriteD & validD;
      ALUSrcE     <= ALUSrcD & validD;
      FlagWriteE  <= FlagWriteD & validD;
    end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flushE && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (stallE && !flushE && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: doc/decode_exe_stage.md
Name: decode_exe_stage

Overview:
- Parametrised Decode-to-Execute pipeline register for the pipelined ARM-style core, sitting between the decode/register-file stage and the ALU/condition-check stage.
- Adds stall (hold), flush (bubble insertion) and a valid bit to the plain D→E register.
- Also pipelines source register addresses (RA1/RA2) for the hazard/forwarding unit.
- Control fields are qualified so that a bubble can never write registers, memory, flags or the PC.

Parameters:
DATA_W, 32, width of RD1, RD2 and the extended immediate
REG_AW, 4, register-address width (RA1, RA2, WA3)
ALUCTL_W, 3, ALU control width
COND_W, 4, condition-field width
FLAG_W, 4, NZCV flags width
CNT_W, 16, performance-counter width (used only with PIPE_PERF_CNT_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
stallE  in  1  hold all E-stage state
flushE  in  1  load bubble into E stage
validD  in  1  decode stage holds a real instruction
RD1D, RD2D  in  DATA_W  register-file read data
ExtImmD  in  DATA_W  extended immediate
RA1D, RA2D  in  REG_AW  source register addresses
WA3D  in  REG_AW  destination register address
CondD  in  COND_W  condition field
FlagsD  in  FLAG_W  current flags
ALUControlD  in  ALUCTL_W  ALU operation
PCSrcD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, FlagWriteD  in  1 each  control bits
validE  out  1  E stage holds a real instruction
RD1E, RD2E, ExtImmE  out  DATA_W  registered data
RA1E, RA2E, WA3E  out  REG_AW  registered addresses
CondE  out  COND_W;  FlagsE  out  FLAG_W;  ALUControlE  out  ALUCTL_W
PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagWriteE  out  1 each
stall_cnt, flush_cnt  out  CNT_W  performance counters (present only with PIPE_PERF_CNT_EN)

Behaviour:
- Single clock domain. Every output is registered, with 1-cycle latency from D inputs to E outputs. There is no combinational path from input to output.
- Update priority, evaluated at each rising clk edge: reset > flushE > stallE > load.
- reset=1: every output is 0, including validE, all data, all addresses, CondE, FlagsE and ALUControlE.
- flushE=1 (reset=0): bubble.
  - validE=0.
  - All six control bits, ALUControlE and CondE are set to 0.
  - Data, addresses and flags are also set to 0, for determinism.
  - Flush wins over a simultaneous stallE=1.
- stallE=1 (reset=0, flushE=0): every output holds its previous value, including validE.
- Load (no reset, flush or stall):
  - All data, address, Cond, Flags and ALUControl fields copy their D inputs.
  - validE=validD.
  - Each control bit E = control bit D AND validD. An invalid decode slot therefore always enters as a bubble with all control bits 0, while data still loads.
- Invariant: validE=0 implies PCSrcE=RegWriteE=MemWriteE=FlagWriteE=MemtoRegE=0.
- Reset may assert in any cycle, including mid-stall. The next edge yields the all-zero state regardless of stallE/flushE.
- All widths come from the parameters; no truncation or extension is done inside the block.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt and flush_cnt ports exist, cleared by reset.
  - stall_cnt increments on each edge with stallE=1 and flushE=0.
  - flush_cnt increments on each edge with flushE=1.
  - Both counters saturate at 2^CNT_W−1 and do not wrap.
- Undefined: the counters and their ports are omitted. All other behaviour is identical.

Test Plan:
- Reset then load: reset=1 for 2 cycles → all outputs 0. Then drive validD=1, RD1D=32'hDEADBEEF, WA3D=4'd7, RegWriteD=1, ALUControlD=3'b010 → one edge later RD1E=32'hDEADBEEF, WA3E=7, RegWriteE=1, validE=1.
- Stall hold: with E loaded (RD2E=32'h12345678), assert stallE for 3 cycles while changing RD2D=32'hFFFFFFFF → RD2E stays 32'h12345678 and validE stays 1. Release stallE → next edge RD2E=32'hFFFFFFFF.
- Flush vs stall: stallE=1 and flushE=1 together with MemWriteD=1, validD=1 → next edge validE=0, MemWriteE=0, RD1E=0, CondE=0.
- Invalid slot: validD=0, RegWriteD=1, FlagWriteD=1, RD1D=32'hA5A5A5A5 → validE=0, RegWriteE=0, FlagWriteE=0, RD1E=32'hA5A5A5A5.
- Reset mid-stall: stallE=1 held with E loaded, pulse reset=1 for 1 cycle → next edge all outputs 0. Stall then continues to hold the zeros.
- PIPE_PERF_CNT_EN with CNT_W=2: 5 stall-only cycles → stall_cnt=3 (saturated). 2 flush cycles with stallE=1 → flush_cnt=2, and stall_cnt stays unchanged during those cycles.
